// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store path.
//   F3_*      : RV32I load/store funct3 width/sign encodings
//   LSU_*     : load/store unit FSM state encodings
package riscv_pkg;

    // funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // LSU state encoding
    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_REQ  = 2'd1;
    localparam logic [1:0] LSU_WAIT = 2'd2;
    localparam logic [1:0] LSU_RESP = 2'd3;

endpackage

// File: rtl/load_store_unit_if.sv
// Bus interfaces of the load/store unit.
//   lsu_core_if : core-side request (in_*) and writeback response (out_*)
//                 modport slave  -> used by the LSU
//                 modport master -> used by the requester (pipeline / bench)
//   lsu_mem_if  : data-memory req/gnt/rvalid port
//                 modport master -> used by the LSU
//                 modport slave  -> used by the memory (model)
interface lsu_core_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_we;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        out_valid;
    logic [31:0] out_rdata;
    logic        out_err;

    modport slave (
        input  in_valid, in_we, in_funct3, in_addr, in_wdata,
        output in_ready, out_valid, out_rdata, out_err
    );

    modport master (
        output in_valid, in_we, in_funct3, in_addr, in_wdata,
        input  in_ready, out_valid, out_rdata, out_err
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   funct3_i     : access width/sign
//   we_i         : 1 = store
//   addr_lo_i    : byte offset within the word
//   wdata_i      : store data (rs2)
//   rdata_i      : raw memory read word
//   be_o         : byte enables
//   wdata_o      : store data replicated across lanes
//   rdata_o      : extracted and sign/zero-extended load data
//   misaligned_o : halfword on odd address or word not on 4-byte boundary
//   illegal_o    : unsupported funct3 for this access direction
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        we_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [31:0] shifted_rdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Move the addressed byte/half down to bit 0
    assign shifted_rdata = rdata_i >> {addr_lo_i, 3'b000};
    assign byte_sel      = shifted_rdata[7:0];
    assign half_sel      = shifted_rdata[15:0];

    always_comb begin
        be_o         = 4'b0000;
        wdata_o      = wdata_i;
        rdata_o      = 32'h0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (funct3_i)
            F3_B, F3_BU: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = (funct3_i == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'h0, byte_sel};
            end
            F3_H, F3_HU: begin
                be_o         = 4'b0011 << addr_lo_i;
                wdata_o      = {2{wdata_i[15:0]}};
                rdata_o      = (funct3_i == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                                  : {16'h0, half_sel};
                misaligned_o = addr_lo_i[0];
            end
            F3_W: begin
                be_o         = 4'b1111;
                wdata_o      = wdata_i;
                rdata_o      = rdata_i;
                misaligned_o = |addr_lo_i;
            end
            default: illegal_o = 1'b1;
        endcase
        // Unsigned variants only exist for loads
        if (we_i && funct3_i[2]) begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one load or store per request against a req/gnt/rvalid port.
//   clk, rst_n : clock, asynchronous active-low reset
//   core       : lsu_core_if.slave  - in_valid/in_ready request, out_valid response
//   mem        : lsu_mem_if.master  - data memory request/response
// Parameters:
//   TIMEOUT_CYC : cycles allowed in REQ or WAIT before an error response
//   CNT_W       : timeout counter width, 2**CNT_W must exceed TIMEOUT_CYC
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_core_if.slave   core,
    lsu_mem_if.master   mem
);

    logic [1:0]       state_q,  state_d;
    logic             we_q,     we_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      addr_q,   addr_d;
    logic [31:0]      wdata_q,  wdata_d;
    logic [31:0]      rdata_q,  rdata_d;
    logic             err_q,    err_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic        idle;
    logic        in_req;
    logic        accept;
    logic        timeout;

    logic [2:0]  al_funct3;
    logic        al_we;
    logic [1:0]  al_addr_lo;
    logic [31:0] al_wdata;
    logic [3:0]  al_be;
    logic [31:0] al_wdata_rep;
    logic [31:0] al_rdata;
    logic        al_misaligned;
    logic        al_illegal;

    assign idle    = (state_q == LSU_IDLE);
    assign in_req  = (state_q == LSU_REQ);
    assign accept  = idle && core.in_valid;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // In IDLE the aligner looks at the incoming request so the error check
    // is available at accept; otherwise it works on the captured request.
    assign al_funct3  = idle ? core.in_funct3     : funct3_q;
    assign al_we      = idle ? core.in_we         : we_q;
    assign al_addr_lo = idle ? core.in_addr[1:0]  : addr_q[1:0];
    assign al_wdata   = idle ? core.in_wdata      : wdata_q;

    lsu_align u_align (
        .funct3_i     (al_funct3),
        .we_i         (al_we),
        .addr_lo_i    (al_addr_lo),
        .wdata_i      (al_wdata),
        .rdata_i      (mem.mem_rdata),
        .be_o         (al_be),
        .wdata_o      (al_wdata_rep),
        .rdata_o      (al_rdata),
        .misaligned_o (al_misaligned),
        .illegal_o    (al_illegal)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    we_d     = core.in_we;
                    funct3_d = core.in_funct3;
                    addr_d   = core.in_addr;
                    wdata_d  = core.in_wdata;
                    rdata_d  = 32'h0;
                    cnt_d    = '0;
                    if (al_misaligned || al_illegal) begin
                        err_d   = 1'b1;
                        state_d = LSU_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (mem.mem_gnt) begin
                    cnt_d   = '0;
                    state_d = we_q ? LSU_RESP : LSU_WAIT;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = LSU_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSU_WAIT: begin
                if (mem.mem_rvalid) begin
                    rdata_d = al_rdata;
                    state_d = LSU_RESP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = LSU_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LSU_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Memory-side outputs decode straight from the state register, so they
    // are stable for the whole REQ phase and drop as soon as reset asserts.
    assign mem.mem_req   = in_req;
    assign mem.mem_we    = in_req && we_q;
    assign mem.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem.mem_be    = in_req ? al_be : 4'b0000;
    assign mem.mem_wdata = in_req ? al_wdata_rep : 32'h0;

    assign core.in_ready  = idle;
    assign core.out_valid = (state_q == LSU_RESP);
    assign core.out_rdata = rdata_q;
    assign core.out_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_core_if core_bus ();
    lsu_mem_if  mem_bus ();

    load_store_unit #(
        .TIMEOUT_CYC (16),
        .CNT_W       (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (core_bus),
        .mem   (mem_bus)
    );

    int tests = 0;
    int fails = 0;
    // Scoreboard entries: {err, rdata}
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: pop the scoreboard on every completed access
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && core_bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("stray_out_valid", 32'(core_bus.out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("[TB] resp rdata=%h err=%b (expected rdata=%h err=%b)",
                         core_bus.out_rdata, core_bus.out_err, e[31:0], e[32]);
                check("out_rdata", core_bus.out_rdata, e[31:0]);
                check("out_err", 32'(core_bus.out_err), 32'(e[32]));
            end
        end
    end

    // One access with a zero-wait memory (gnt in first REQ cycle, rvalid next)
    task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                             input logic exp_err);
        $display("[TB] req %s we=%b f3=%b addr=%h wdata=%h", tag, we, f3, addr, wdata);
        @(posedge clk); #1;
        core_bus.in_valid  = 1'b1;
        core_bus.in_we     = we;
        core_bus.in_funct3 = f3;
        core_bus.in_addr   = addr;
        core_bus.in_wdata  = wdata;
        exp_q.push_back({exp_err, exp_rdata});
        @(posedge clk); #1;
        core_bus.in_valid = 1'b0;
        if (exp_err) begin
            @(negedge clk);
            check({tag, "_no_req"}, 32'(mem_bus.mem_req), 32'd0);
            check({tag, "_lat1"}, 32'(core_bus.out_valid), 32'd1);
        end else begin
            mem_bus.mem_gnt = 1'b1;
            @(negedge clk);
            check({tag, "_req"}, 32'(mem_bus.mem_req), 32'd1);
            check({tag, "_we"}, 32'(mem_bus.mem_we), 32'(we));
            check({tag, "_addr"}, mem_bus.mem_addr, {addr[31:2], 2'b00});
            check({tag, "_be"}, 32'(mem_bus.mem_be), 32'(exp_be));
            if (we) check({tag, "_wdata"}, mem_bus.mem_wdata, exp_wdata);
            @(posedge clk); #1;
            mem_bus.mem_gnt = 1'b0;
            if (!we) begin
                mem_bus.mem_rvalid = 1'b1;
                mem_bus.mem_rdata  = rdata;
                @(negedge clk);
                check({tag, "_wait_noreq"}, 32'(mem_bus.mem_req), 32'd0);
                check({tag, "_wait_novalid"}, 32'(core_bus.out_valid), 32'd0);
                @(posedge clk); #1;
                mem_bus.mem_rvalid = 1'b0;
            end
            @(negedge clk);
            check({tag, we ? "_lat2" : "_lat3"}, 32'(core_bus.out_valid), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  req_cyc;
        bit  seen;
        int  late_valid;

        core_bus.in_valid  = 1'b0;
        core_bus.in_we     = 1'b0;
        core_bus.in_funct3 = 3'b000;
        core_bus.in_addr   = 32'h0;
        core_bus.in_wdata  = 32'h0;
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(core_bus.in_ready), 32'd1);
        check("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_bus.mem_we), 32'd0);
        check("rst_mem_be", 32'(mem_bus.mem_be), 32'd0);
        check("rst_mem_addr", mem_bus.mem_addr, 32'd0);
        check("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
        check("rst_out_valid", 32'(core_bus.out_valid), 32'd0);
        check("rst_out_rdata", core_bus.out_rdata, 32'd0);
        check("rst_out_err", 32'(core_bus.out_err), 32'd0);
        rst_n = 1'b1;

        do_access("SW",   1'b1, F3_W,  32'h100,  32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0,        1'b0);
        do_access("LB",   1'b0, F3_B,  32'h203,  32'h0,        32'h80FF0000, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0);
        do_access("LBU",  1'b0, F3_BU, 32'h203,  32'h0,        32'h80FF0000, 4'b1000, 32'h0,        32'h00000080, 1'b0);
        do_access("LHmis",1'b0, F3_H,  32'h1001, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
        do_access("SH",   1'b1, F3_H,  32'h2,    32'h00001234, 32'h0,        4'b1100, 32'h12341234, 32'h0,        1'b0);
        do_access("LH",   1'b0, F3_H,  32'h2,    32'h0,        32'h80FF0000, 4'b1100, 32'h0,        32'hFFFF80FF, 1'b0);
        do_access("LHU",  1'b0, F3_HU, 32'h2,    32'h0,        32'h80FF0000, 4'b1100, 32'h0,        32'h000080FF, 1'b0);
        do_access("SB",   1'b1, F3_B,  32'h1,    32'h000000AB, 32'h0,        4'b0010, 32'hABABABAB, 32'h0,        1'b0);
        do_access("LWmis",1'b0, F3_W,  32'h42,   32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
        do_access("Lf011",1'b0, 3'b011,32'h40,   32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);
        do_access("SBU",  1'b1, F3_BU, 32'h40,   32'h55,       32'h0,        4'b0000, 32'h0,        32'h0,        1'b1);

        // Timeout: gnt never arrives
        $display("[TB] req LW_timeout addr=00000080");
        @(posedge clk); #1;
        core_bus.in_valid  = 1'b1;
        core_bus.in_we     = 1'b0;
        core_bus.in_funct3 = F3_W;
        core_bus.in_addr   = 32'h80;
        exp_q.push_back({1'b1, 32'h0});
        @(posedge clk); #1;
        core_bus.in_valid = 1'b0;
        req_cyc = 0;
        seen    = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (core_bus.out_valid === 1'b1) seen = 1'b1;
            else if (mem_bus.mem_req === 1'b1) req_cyc++;
        end
        check("timeout_seen", 32'(seen), 32'd1);
        check("timeout_req_cycles", 32'(req_cyc), 32'd16);
        check("timeout_req_dropped", 32'(mem_bus.mem_req), 32'd0);
        // Late data after the timeout must not produce a response
        @(posedge clk); #1;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'hCAFEF00D;
        @(posedge clk); #1;
        mem_bus.mem_rvalid = 1'b0;
        late_valid = 0;
        repeat (4) begin
            @(negedge clk);
            if (core_bus.out_valid === 1'b1) late_valid++;
        end
        check("late_rvalid_ignored", 32'(late_valid), 32'd0);

        // Reset while waiting for load data
        $display("[TB] req LW_abort addr=00000044");
        @(posedge clk); #1;
        core_bus.in_valid  = 1'b1;
        core_bus.in_we     = 1'b0;
        core_bus.in_funct3 = F3_W;
        core_bus.in_addr   = 32'h44;
        @(posedge clk); #1;
        core_bus.in_valid = 1'b0;
        mem_bus.mem_gnt   = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_gnt = 1'b0;
        check("wait_in_ready", 32'(core_bus.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("abort_in_ready", 32'(core_bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(core_bus.out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        late_valid = 0;
        repeat (3) begin
            @(negedge clk);
            if (core_bus.out_valid === 1'b1) late_valid++;
        end
        check("abort_no_resp", 32'(late_valid), 32'd0);

        do_access("LW",   1'b0, F3_W,  32'h40,   32'h0,        32'h12345678, 4'b1111, 32'h0,        32'h12345678, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
